// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and default datapath sizes
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_GT  = 3'd5;
  localparam logic [OP_W-1:0] OP_EQ  = 3'd6;
  localparam logic [OP_W-1:0] OP_NOP = 3'd7;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ALU_LAT = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, lowest index at or after ptr wins
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    int   cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      // Walk candidates ptr, ptr+1, ... modulo N; the first requester seen wins.
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - shares one pipelined ALU among requesters, tags results with requester id
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ALU_LAT = DEF_ALU_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_sel,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_carry,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_carry,
  output logic                      busy
);

  logic [ID_W-1:0]              ptr;
  logic [ID_W-1:0]              gnt_idx;
  logic [NUM_REQ-1:0]           gnt;
  logic                         hs;
  logic [ALU_LAT:0]             tag_valid;
  logic [ALU_LAT:0][ID_W-1:0]   tag_id;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No grant may leak out while the block is held in reset.
  assign req_ready = rst ? gnt : '0;
  assign hs        = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= OP_ADD;
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      // Tag shift register runs in lockstep with the ALU register stages.
      tag_valid <= {tag_valid[ALU_LAT-1:0], hs};
      tag_id    <= {tag_id[ALU_LAT-1:0], gnt_idx};
      if (hs) begin
        ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        alu_a   <= req_a[gnt_idx*DATA_W +: DATA_W];
        alu_b   <= req_b[gnt_idx*DATA_W +: DATA_W];
        alu_sel <= req_op[gnt_idx*OP_W +: OP_W];
      end
    end
  end

  assign rsp_valid  = tag_valid[ALU_LAT];
  assign rsp_id     = tag_id[ALU_LAT];
  assign rsp_result = alu_result;
  assign rsp_carry  = alu_carry;
  assign busy       = |tag_valid;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - directed bench for alu_req_scheduler with a two-stage ALU model
module tb_alu_req_scheduler;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [11:0] req_op;
  logic [3:0]  req_ready;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [3:0]  alu_result;
  logic        alu_carry;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic        rsp_carry;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_req_scheduler dut (
    .clk        (clk),
    .rst        (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  // ALU stand-in: input register then output register, reset from ~rst.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    case (op)
      OP_ADD:  alu_fn = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_fn = {1'b0, a} - {1'b0, b};
      OP_AND:  alu_fn = {1'b0, a & b};
      OP_OR:   alu_fn = {1'b0, a | b};
      OP_XOR:  alu_fn = {1'b0, a ^ b};
      OP_GT:   alu_fn = {4'b0, a > b};
      OP_EQ:   alu_fn = {4'b0, a == b};
      default: alu_fn = 5'b0;
    endcase
  endfunction

  logic [3:0] ia, ib;
  logic [2:0] isel;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ia <= '0; ib <= '0; isel <= '0; alu_result <= '0; alu_carry <= 1'b0;
    end else begin
      ia <= alu_a; ib <= alu_b; isel <= alu_sel;
      {alu_carry, alu_result} <= alu_fn(ia, ib, isel);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op);
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
    req_op[i*3 +: 3] = op;
  endtask

  logic [3:0] rot_res [4] = '{4'h2, 4'h2, 4'h5, 4'h0};
  logic       rot_cy  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  int         n_rsp;

  initial begin
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_a = 16'h1234; req_b = 16'h5678; req_op = 12'h2D1;

    // Reset held with every requester valid
    tick; tick; mid;
    check("rst_ready", req_ready, 4'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_sel", alu_sel, 3'd0);
    check("rst_alu_a", alu_a, 4'd0);
    check("rst_busy", busy, 1'b0);

    tick; rst_n = 1'b1; req_valid = 4'h0; mid;
    check("idle_ready", req_ready, 4'h0);

    // Single op: 9 + 8 -> 1 with carry, three cycles later
    tick; set_req(0, 4'd9, 4'd8, OP_ADD); req_valid = 4'b0001; mid;
    check("single_gnt", req_ready, 4'b0001);
    tick; req_valid = 4'h0; mid;
    check("single_alu_a", alu_a, 4'd9);
    check("single_alu_b", alu_b, 4'd8);
    check("single_alu_sel", alu_sel, OP_ADD);
    check("single_busy", busy, 1'b1);
    check("single_rsp_early1", rsp_valid, 1'b0);
    tick; mid;
    check("single_rsp_early2", rsp_valid, 1'b0);
    tick; mid;
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_rsp_id", rsp_id, 2'd0);
    check("single_rsp_result", rsp_result, 4'd1);
    check("single_rsp_carry", rsp_carry, 1'b1);
    tick; mid;
    check("single_rsp_done", rsp_valid, 1'b0);
    check("single_busy_done", busy, 1'b0);

    // Reset pulse returns the pointer to 0 before the rotation test
    tick; rst_n = 1'b0; mid;
    tick; rst_n = 1'b1;

    // Rotation: all four valid for eight cycles
    set_req(0, 4'h9, 4'h9, OP_ADD);
    set_req(1, 4'h3, 4'h1, OP_SUB);
    set_req(2, 4'h6, 4'h3, OP_XOR);
    set_req(3, 4'hF, 4'hF, OP_NOP);
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick;
      if (k == 8) req_valid = 4'h0;
      mid;
      if (k < 8) check($sformatf("rot_gnt%0d", k), req_ready, 4'b0001 << (k % 4));
      if (k >= 3 && k < 11) begin
        check($sformatf("rot_rsp_valid%0d", k), rsp_valid, 1'b1);
        check($sformatf("rot_rsp_id%0d", k), rsp_id, (k - 3) % 4);
        check($sformatf("rot_rsp_res%0d", k), rsp_result, rot_res[(k - 3) % 4]);
        check($sformatf("rot_rsp_cy%0d", k), rsp_carry, rot_cy[(k - 3) % 4]);
      end else begin
        check($sformatf("rot_rsp_idle%0d", k), rsp_valid, 1'b0);
      end
    end

    // Back-to-back from requester 2: 5-7 then C&A
    tick; set_req(2, 4'h5, 4'h7, OP_SUB); req_valid = 4'b0100; mid;
    check("b2b_gnt0", req_ready, 4'b0100);
    tick; set_req(2, 4'hC, 4'hA, OP_AND); mid;
    check("b2b_gnt1", req_ready, 4'b0100);
    tick; req_valid = 4'h0; mid;
    check("b2b_no_gnt", req_ready, 4'h0);
    tick; mid;
    check("b2b_rsp0_valid", rsp_valid, 1'b1);
    check("b2b_rsp0_id", rsp_id, 2'd2);
    check("b2b_rsp0_res", rsp_result, 4'hE);
    check("b2b_rsp0_cy", rsp_carry, 1'b1);
    tick; mid;
    check("b2b_rsp1_valid", rsp_valid, 1'b1);
    check("b2b_rsp1_id", rsp_id, 2'd2);
    check("b2b_rsp1_res", rsp_result, 4'h8);
    check("b2b_rsp1_cy", rsp_carry, 1'b0);
    tick; mid;
    check("b2b_rsp_done", rsp_valid, 1'b0);

    // Sparse / wrap with ptr=3, then a request dropped before its grant
    set_req(0, 4'h3, 4'h3, OP_ADD);
    set_req(1, 4'h1, 4'h1, OP_ADD);
    set_req(3, 4'h2, 4'h2, OP_ADD);
    tick; req_valid = 4'b0010; mid;
    check("wrap_gnt1", req_ready, 4'b0010);
    tick; req_valid = 4'b1010; mid;
    check("wrap_gnt3", req_ready, 4'b1000);
    tick; req_valid = 4'b0101; mid;
    check("wrap_gnt0", req_ready, 4'b0001);
    tick; req_valid = 4'h0; mid;
    check("drop_no_gnt", req_ready, 4'h0);
    check("wrap_rsp_id1", rsp_id, 2'd1);
    check("wrap_rsp_res1", rsp_result, 4'd2);
    tick; mid;
    check("wrap_rsp_id3", rsp_id, 2'd3);
    check("wrap_rsp_res3", rsp_result, 4'd4);
    tick; mid;
    check("wrap_rsp_id0", rsp_id, 2'd0);
    check("wrap_rsp_res0", rsp_result, 4'd6);
    tick; mid;
    check("drop_no_rsp", rsp_valid, 1'b0);
    check("drop_busy", busy, 1'b0);

    // Reset one cycle after two issues discards both tags
    tick; req_valid = 4'hF; mid;
    check("mid_gnt1", req_ready, 4'b0010);
    tick; mid;
    check("mid_gnt2", req_ready, 4'b0100);
    check("mid_busy", busy, 1'b1);
    tick; req_valid = 4'h0; rst_n = 1'b0; mid;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp", rsp_valid, 1'b0);
    tick; rst_n = 1'b1;
    n_rsp = 0;
    for (int k = 0; k < 5; k++) begin
      mid;
      if (rsp_valid) n_rsp++;
      tick;
    end
    check("mid_rsp_count", n_rsp, 0);
    check("mid_busy_after", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
